// File: rtl/gbuff_fetch.sv
// ---------------------------------------------------------------------------
// gbuff_fetch -- read-only burst master for the global buffer.
//
// Fetches `length` consecutive words starting at `base_addr` from a global
// buffer with 1-cycle registered read latency. The words go out on a
// valid/ready stream through a 2-entry output FIFO.
//
// Reads are credit-limited. A read issues only when the FIFO occupancy plus
// the read in flight is below 2, or when a stream handshake frees a slot in
// the same cycle. No word can be dropped under backpressure.
//
// Configuration macro: GBUFF_FETCH_WRAP_EN
//   defined   : index wraps modulo 2^ADDR_W and the full length is fetched.
//   undefined : the burst is clamped at the top of the buffer (no wrap).
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   start      in   burst request, sampled only when idle
//   base_addr  in   [ADDR_W] first buffer index of the burst
//   length     in   [LEN_W]  number of words to fetch (0 = empty burst)
//   busy       out  high whenever not idle
//   done       out  one-cycle pulse at burst completion
//   gb_wr_en   out  buffer write enable, tied low
//   gb_index   out  [ADDR_W] buffer read index
//   gb_data    in   [DATA_W] buffer registered read data
//   m_valid    out  stream valid
//   m_ready    in   stream ready
//   m_data     out  [DATA_W] stream data (0 when m_valid is low)
//   m_last     out  marks the final word of the burst
// ---------------------------------------------------------------------------
module gbuff_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              gb_wr_en,
  output logic [ADDR_W-1:0] gb_index,
  input  logic [DATA_W-1:0] gb_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              prime_q, prime_d;        // first FETCH cycle: resolves the effective length
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;    // next index to issue
  logic [LEN_W-1:0]  rem_q, rem_d;            // reads still to issue
  logic [ADDR_W-1:0] idx_hold_q, idx_hold_d;  // last issued index
  logic              in_flight_q, in_flight_d;
  logic              in_flight_last_q, in_flight_last_d;

  // 2-entry output FIFO
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic              fifo_last_q [2];
  logic              fifo_last_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              pop;
  logic              issue;
  logic              last_issue;
  logic [2:0]        credit_used;
  logic [LEN_W-1:0]  eff_len;

`ifdef GBUFF_FETCH_WRAP_EN
  // Wrapping index: the requested length is fetched unchanged.
  always_comb begin
    eff_len = rem_q;
  end
`else
  // Clamp the burst so that it never crosses the top of the buffer.
  // SPAN_W must hold 2^ADDR_W as well as any length value.
  localparam int SPAN_W = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
  logic [SPAN_W-1:0] span;

  always_comb begin
    span    = (SPAN_W'(1) << ADDR_W) - SPAN_W'(rd_addr_q);
    eff_len = (SPAN_W'(rem_q) > span) ? LEN_W'(span) : rem_q;
  end
`endif

  always_comb begin
    // NOTE: every signal written here first gets a default. Without one, some
    // path would leave it unassigned and synthesis would infer a latch.
    state_d          = state_q;
    prime_d          = 1'b0;
    rd_addr_d        = rd_addr_q;
    rem_d            = rem_q;
    idx_hold_d       = idx_hold_q;
    in_flight_d      = 1'b0;
    in_flight_last_d = 1'b0;
    fifo_data_d      = fifo_data_q;
    fifo_last_d      = fifo_last_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;

    pop         = (count_q != 2'd0) && m_ready;
    credit_used = {1'b0, count_q} + {2'b00, in_flight_q};
    issue       = (state_q == S_FETCH) && !prime_q && (rem_q != '0) &&
                  ((credit_used < 3'd2) || pop);
    last_issue  = issue && (rem_q == LEN_W'(1));

    if (issue) begin
      idx_hold_d       = rd_addr_q;
      rd_addr_d        = rd_addr_q + ADDR_W'(1);
      rem_d            = rem_q - LEN_W'(1);
      in_flight_d      = 1'b1;
      in_flight_last_d = last_issue;
    end

    // The read issued last cycle is now on gb_data. Capture it into the FIFO.
    if (in_flight_q) begin
      fifo_data_d[wr_ptr_q] = gb_data;
      fifo_last_d[wr_ptr_q] = in_flight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, in_flight_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            rd_addr_d = base_addr;
            rem_d     = length;
            prime_d   = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (prime_q) begin
          rem_d = eff_len;
        end
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state always uses non-blocking assignments. Every flop
  // then samples its pre-edge value, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q          <= S_IDLE;
      prime_q          <= 1'b0;
      rd_addr_q        <= '0;
      rem_q            <= '0;
      idx_hold_q       <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
    end else begin
      state_q          <= state_d;
      prime_q          <= prime_d;
      rd_addr_q        <= rd_addr_d;
      rem_q            <= rem_d;
      idx_hold_q       <= idx_hold_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset. The count and pointers
  // define which entries are valid, and the outputs are gated by m_valid,
  // so stale contents are never visible.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_last_q <= fifo_last_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign gb_wr_en = 1'b0;
  // A new index appears in the cycle its read issues; otherwise the last one
  // is held, and the buffer re-reads it harmlessly.
  assign gb_index = issue ? rd_addr_q : idx_hold_q;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last   = m_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_gbuff_fetch.sv
// ---------------------------------------------------------------------------
// tb_gbuff_fetch -- directed self-checking bench for gbuff_fetch.
// The buffer model holds mem[i] = i and has a 1-cycle registered read.
// ---------------------------------------------------------------------------
module tb_gbuff_fetch;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;

`ifdef GBUFF_FETCH_WRAP_EN
  localparam int WRAP_N = 4;
`else
  localparam int WRAP_N = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              gb_wr_en;
  logic [ADDR_W-1:0] gb_index;
  logic [DATA_W-1:0] gb_data = '0;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  int checks = 0;
  int errors = 0;

  gbuff_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .gb_wr_en  (gb_wr_en),
    .gb_index  (gb_index),
    .gb_data   (gb_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Global buffer model: mem[i] = i, registered read
  always @(posedge clk) gb_data <= DATA_W'(gb_index);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " done"},     32'(done),     32'd0);
    check({tag, " gb_wr_en"}, 32'(gb_wr_en), 32'd0);
    check({tag, " gb_index"}, 32'(gb_index), 32'd0);
    check({tag, " m_valid"},  32'(m_valid),  32'd0);
    check({tag, " m_data"},   m_data,        32'd0);
    check({tag, " m_last"},   32'(m_last),   32'd0);
  endtask

  // Burst with a ready pattern and a stream monitor.
  // mode 0: ready held high, mode 1: 1,0,0 repeating, mode 2: random.
  // inject: pulse start with a different base while the burst is active.
  task automatic run_burst(input string tag, input logic [7:0] b, input logic [8:0] l,
                           input int mode, input int exp_n, input bit inject);
    int          n;
    int          cyc;
    int          done_cnt;
    bit          stalled;
    logic [31:0] hold_data;
    logic [7:0]  exp_addr;
    base_addr = b;
    length    = l;
    start     = 1'b1;
    m_ready   = 1'b0;
    step();
    start     = 1'b0;
    n         = 0;
    cyc       = 0;
    done_cnt  = 0;
    stalled   = 1'b0;
    hold_data = '0;
    while (done_cnt == 0 && cyc < 2000) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 3) begin
        start     = 1'b1;
        base_addr = 8'h80;
        length    = 9'd2;
      end else begin
        start = 1'b0;
      end
      if (stalled) begin
        check({tag, " stall valid"}, 32'(m_valid), 32'd1);
        check({tag, " stall data"},  m_data,       hold_data);
      end
      if (m_valid && m_ready) begin
        exp_addr = b + n[7:0];
        check({tag, " data"}, m_data,       32'(exp_addr));
        check({tag, " last"}, 32'(m_last), 32'(n == exp_n - 1));
        n++;
      end
      stalled   = m_valid && !m_ready;
      hold_data = m_data;
      step();
      cyc++;
      if (done) done_cnt++;
    end
    start = 1'b0;
    check({tag, " word count"}, 32'(n), 32'(exp_n));
    check({tag, " done seen"}, 32'(done_cnt), 32'd1);
    m_ready = 1'b0;
    step();
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int quiet_hits;
    logic [31:0] exp_v [9];
    logic [31:0] exp_d [9];
    logic [31:0] exp_l [9];
    logic [31:0] exp_dn[9];
    logic [31:0] exp_b [9];

    rst_n     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b0;
    step();

    // Latency and throughput: base 0x10, length 4, ready held high.
    // Rows are the states after edges E0..E8, where E0 samples start.
    exp_v  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    exp_d  = '{0, 0, 0, 32'h10, 32'h11, 32'h12, 32'h13, 0, 0};
    exp_l  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    exp_b  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    base_addr = 8'h10;
    length    = 9'd4;
    m_ready   = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      start = 1'b0;
      check($sformatf("t1 E%0d m_valid", i), 32'(m_valid), exp_v[i]);
      check($sformatf("t1 E%0d m_data", i),  m_data,       exp_d[i]);
      check($sformatf("t1 E%0d m_last", i),  32'(m_last),  exp_l[i]);
      check($sformatf("t1 E%0d done", i),    32'(done),    exp_dn[i]);
      check($sformatf("t1 E%0d busy", i),    32'(busy),    exp_b[i]);
    end
    check("t1 gb_wr_en", 32'(gb_wr_en), 32'd0);

    // Backpressure 1,0,0 pattern
    run_burst("t2 toggle", 8'h00, 9'd8, 1, 8, 1'b0);

    // Top-of-buffer boundary
    run_burst("t3 wrap", 8'hFE, 9'd4, 0, WRAP_N, 1'b0);

    // Zero-length burst
    base_addr = 8'h30;
    length    = 9'd0;
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("t4 busy", 32'(busy), 32'd1);
    check("t4 done", 32'(done), 32'd1);
    check("t4 m_valid", 32'(m_valid), 32'd0);
    step();
    check("t4 busy after", 32'(busy), 32'd0);
    check("t4 done after", 32'(done), 32'd0);
    check("t4 m_valid after", 32'(m_valid), 32'd0);

    // Reset in the middle of a 6-word burst
    base_addr = 8'h20;
    length    = 9'd6;
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 2 && cyc < 50) begin
      if (m_valid && m_ready) n++;
      step();
      cyc++;
    end
    check("t5 words before reset", 32'(n), 32'd2);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check_reset_outputs("t5 post-reset");
    quiet_hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || m_valid || busy) quiet_hits++;
    end
    check("t5 no resume", 32'(quiet_hits), 32'd0);
    run_burst("t5 new burst", 8'h50, 9'd3, 0, 3, 1'b0);

    // A start pulse during a burst is ignored
    run_burst("t6 ignore start", 8'h40, 9'd6, 0, 6, 1'b1);

    // Random backpressure
    run_burst("t7 random", 8'h60, 9'd20, 2, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbuff_fetch.md
GBUFF_FETCH -- requirements
Module: gbuff_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning global buffer index width (256 entries).
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width (`WORD_SIZE).
REQ-003 SHALL have parameter LEN_W, default 9, meaning burst length width (0..256).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-high reset (1 = reset).
REQ-006 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_W  first buffer index of burst.
REQ-008 SHALL have port length  input  LEN_W  number of words to fetch.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port gb_wr_en  output  1  buffer write enable, constant 0 (read-only master).
REQ-012 SHALL have port gb_index  output  ADDR_W  buffer read index.
REQ-013 SHALL have port gb_data  input  DATA_W  buffer registered read data.
REQ-014 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_W, m_last output 1: downstream stream.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: start=1 with length>0 SHALL latch base_addr/length and enter FETCH; start with length=0 SHALL enter DONE directly, issuing no reads.
REQ-017 start while busy SHALL be ignored; latched parameters SHALL NOT change mid-burst.
REQ-018 Buffer read latency is 1 cycle: index driven in cycle t, gb_data captured at end of cycle t+1 into a 2-entry output FIFO.
REQ-019 A read SHALL issue in a cycle only if (fifo_occupancy + in_flight) < 2, or a stream handshake (m_valid & m_ready) occurs that cycle.
REQ-020 With m_ready held high, throughput SHALL be 1 word/cycle; first m_valid SHALL assert on the 3rd rising edge after the edge sampling start.
REQ-021 Words SHALL be output in order base_addr, base_addr+1, ...; m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 m_last SHALL be 1 exactly with the final word of the burst.
REQ-023 FETCH -> DRAIN after final read issued; DRAIN -> DONE after final word handshake; DONE lasts one cycle with done=1, then IDLE.
REQ-024 No word SHALL be dropped or duplicated under any m_ready pattern.
REQ-025 gb_index SHALL hold the last issued index when no read issues (buffer re-reads harmlessly).

Reset
REQ-026 rst_n=1 at a rising edge SHALL force IDLE, flush FIFO, clear in-flight flag, regardless of state.
REQ-027 Reset values: busy=0, done=0, gb_wr_en=0, gb_index=0, m_valid=0, m_data=0, m_last=0.
REQ-028 A burst interrupted by reset SHALL NOT resume; no done pulse SHALL be produced for it.

Configuration
REQ-029 Macro GBUFF_FETCH_WRAP_EN defined: index SHALL wrap modulo 2^ADDR_W (255 -> 0), full length fetched.
REQ-030 Macro undefined: effective length SHALL be clamped to 2^ADDR_W - base_addr; index never wraps.

Verification
REQ-031 Buffer loaded mem[i]=i; base=0x10, length=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done one cycle after.
REQ-032 base=0x00, length=8, m_ready toggling 1,0,0,1,... -> all 8 words in order, none lost/duplicated, data stable while stalled.
REQ-033 base=0xFE, length=4: with WRAP_EN -> 0xFE,0xFF,0x00,0x01; without -> 0xFE,0xFF only, m_last on 0xFF.
REQ-034 length=0, start=1 -> no m_valid, done pulse one cycle later, busy high for exactly one cycle.
REQ-035 rst_n=1 asserted after 2 of 6 words delivered -> all outputs at reset values next cycle, no done; new burst then runs correctly.
REQ-036 start pulsed during an active burst with different base -> ignored, original burst completes unchanged.
